// File: rtl/config_pkg.sv
// config_pkg: shared state encoding and default sizes for the configuration loader
package config_pkg;
  localparam int CONFIG_L_DEF = 32;
  localparam int N_REG_DEF = 21;
  typedef enum logic [1:0] {IDLE, LOAD, READBACK} state_t;
endpackage

// File: rtl/config_loader.sv
// config_loader: loads/rotates an external configuration shift chain; readback enabled by CONFIG_READBACK_EN
module config_loader
  import config_pkg::*;
#(
  parameter int CONFIG_L = CONFIG_L_DEF,
  parameter int N_REG = N_REG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                readback,
  input  logic                abort,
  input  logic [CONFIG_L-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CONFIG_L-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CONFIG_L-1:0] cfg_data_in,
  input  logic [CONFIG_L-1:0] cfg_data_out,
  output logic                cfg_shift_en,
  output logic                cfg_valid,
  output logic                busy
);
  localparam int CW = $clog2(N_REG + 1);
  localparam logic [CW-1:0] LAST = CW'(N_REG - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic valid_n;
`ifndef CONFIG_READBACK_EN
  logic unused_rb;
  assign unused_rb = &{readback, out_ready, cfg_data_out};
`endif
  assign busy = state != IDLE;
  // next state, counter and chain/handshake drive; abort suppresses the shift of its cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    valid_n = cfg_valid;
    in_ready = 1'b0;
    out_valid = 1'b0;
    out_data = '0;
    cfg_shift_en = 1'b0;
    cfg_data_in = '0;
    unique case (state)
      IDLE: begin
        if (abort) state_n = IDLE;
        else if (start) begin
          cnt_n = '0;
          valid_n = 1'b0;
          state_n = LOAD;
        end
`ifdef CONFIG_READBACK_EN
        else if (readback && cfg_valid) begin
          cnt_n = '0;
          valid_n = 1'b0;
          state_n = READBACK;
        end
`endif
      end
      LOAD: begin
        in_ready = 1'b1;
        cfg_shift_en = in_valid && !abort;
        cfg_data_in = cfg_shift_en ? in_data : '0;
        if (abort) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end else if (cfg_shift_en) begin
          cnt_n = cnt + 1'b1;
          valid_n = cnt == LAST;
          state_n = cnt == LAST ? IDLE : LOAD;
        end
      end
`ifdef CONFIG_READBACK_EN
      READBACK: begin
        out_valid = 1'b1;
        out_data = cfg_data_out;
        cfg_shift_en = out_ready && !abort;
        cfg_data_in = cfg_shift_en ? cfg_data_out : '0;
        if (abort) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end else if (cfg_shift_en) begin
          cnt_n = cnt + 1'b1;
          valid_n = cnt == LAST;
          state_n = cnt == LAST ? IDLE : READBACK;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cfg_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cfg_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: randomized scoreboard bench for config_loader with an ideal chain model
module tb_config_loader;
  localparam int W = 32;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, start, readback, abort, in_valid, out_ready;
  logic [W-1:0] in_data, out_data, cfg_data_in, cfg_data_out;
  logic in_ready, out_valid, cfg_shift_en, cfg_valid, busy;
  logic [W-1:0] chain [N];
  logic [W-1:0] exp_shift [$];
  logic [W-1:0] exp_out [$];
  logic [W-1:0] golden [$];
  int n_chk = 0;
  int n_fail = 0;

  config_loader #(.CONFIG_L(W), .N_REG(N)) dut (
    .clk(clk), .rst(rst), .start(start), .readback(readback), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_data_in(cfg_data_in), .cfg_data_out(cfg_data_out),
    .cfg_shift_en(cfg_shift_en), .cfg_valid(cfg_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  assign cfg_data_out = chain[N-1];

  // the external chain: head at index 0, tail at N-1
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) chain[i] <= '0;
    end else if (cfg_shift_en) begin
      for (int i = N - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= cfg_data_in;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every shift and every readback beat must match the next expected word
  always @(negedge clk) begin
    if (!rst) begin
      check("exclusive_handshake", {31'b0, in_ready && out_valid}, 0);
      if (!busy) begin
        check("idle_shift_en", {31'b0, cfg_shift_en}, 0);
        check("idle_in_ready", {31'b0, in_ready}, 0);
        check("idle_out_valid", {31'b0, out_valid}, 0);
      end
      if (!cfg_shift_en) check("din_zero_no_shift", cfg_data_in, 0);
      if (cfg_shift_en) begin
        check("shift_expected", {31'b0, exp_shift.size() > 0}, 1);
        if (exp_shift.size() > 0) check("shift_word", cfg_data_in, exp_shift.pop_front());
      end
      if (out_valid && out_ready) begin
        check("rb_expected", {31'b0, exp_out.size() > 0}, 1);
        if (exp_out.size() > 0) check("rb_word", out_data, exp_out.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_chain();
    for (int i = 0; i < N; i++) check("chain_word", chain[N-1-i], golden[i]);
  endtask

  // vmode: 0 in_valid held high, 1 toggled 1,0,1,0..., 2 random
  task automatic do_load(input int vmode, input int abort_at, input bit start_mid);
    logic [W-1:0] words [$];
    int sent = 0;
    int guard = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("load_busy", {31'b0, busy}, 1);
    check("load_valid_cleared", {31'b0, cfg_valid}, 0);
    while (sent < N && guard < 200) begin
      if (sent == abort_at) begin
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = $urandom;
        cyc();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_valid", {31'b0, cfg_valid}, 0);
        return;
      end
      start = start_mid && sent == 2;
      in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? guard % 2 == 0 : 1'($urandom);
      in_data = $urandom;
      if (in_valid) exp_shift.push_back(in_data);
      cyc();
      start = 1'b0;
      if (in_valid) begin
        sent++;
        words.push_back(in_data);
      end
      in_valid = 1'b0;
      guard++;
      if (sent < N) check("load_in_progress", {31'b0, busy && !cfg_valid}, 1);
    end
    check("load_done", {31'b0, busy}, 0);
    check("load_valid", {31'b0, cfg_valid}, 1);
    golden = words;
    check_chain();
  endtask

`ifdef CONFIG_READBACK_EN
  task automatic do_readback(input int abort_at);
    int got = 0;
    int guard = 0;
    readback = 1'b1;
    cyc();
    readback = 1'b0;
    check("rb_busy", {31'b0, busy}, 1);
    check("rb_valid_cleared", {31'b0, cfg_valid}, 0);
    while (got < N && guard < 200) begin
      if (got == abort_at) begin
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("rb_abort_busy", {31'b0, busy}, 0);
        check("rb_abort_valid", {31'b0, cfg_valid}, 0);
        return;
      end
      out_ready = 1'($urandom);
      if (out_ready) begin
        exp_out.push_back(golden[got]);
        exp_shift.push_back(golden[got]);
      end
      cyc();
      if (out_ready) got++;
      out_ready = 1'b0;
      guard++;
    end
    check("rb_done", {31'b0, busy}, 0);
    check("rb_valid", {31'b0, cfg_valid}, 1);
    check_chain();
  endtask
`endif

  initial begin
    rst = 1'b1;
    {start, readback, abort, in_valid, out_ready} = '0;
    in_data = '0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_shift_en", {31'b0, cfg_shift_en}, 0);
    check("rst_cfg_valid", {31'b0, cfg_valid}, 0);
    readback = 1'b1;
    cyc();
    readback = 1'b0;
    check("rb_without_valid_ignored", {31'b0, busy}, 0);
    do_load(0, -1, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    cyc();
    {start, abort} = '0;
    check("start_abort_idle", {31'b0, busy}, 0);
    check("start_abort_keeps_valid", {31'b0, cfg_valid}, 1);
`ifdef CONFIG_READBACK_EN
    do_readback(-1);
    do_readback(2);
    readback = 1'b1;
    cyc();
    readback = 1'b0;
    check("rb_after_abort_ignored", {31'b0, busy}, 0);
`else
    readback = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      readback = 1'b0;
      check("tied_out_valid", {31'b0, out_valid}, 0);
      check("tied_out_data", out_data, 0);
      check("tied_busy", {31'b0, busy}, 0);
    end
    out_ready = 1'b0;
    check("tied_cfg_valid", {31'b0, cfg_valid}, 1);
`endif
    do_load(1, -1, 1'b1);
    do_load(0, 2, 1'b0);
    do_load(2, -1, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom;
      exp_shift.push_back(in_data);
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_in_ready", {31'b0, in_ready}, 0);
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_shift_en", {31'b0, cfg_shift_en}, 0);
    check("midrst_cfg_valid", {31'b0, cfg_valid}, 0);
    for (int k = 0; k < 6; k++) begin
      do_load(2, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, N - 1)) : -1, 1'($urandom));
`ifdef CONFIG_READBACK_EN
      if (cfg_valid) do_readback($urandom_range(0, 3) == 0 ? int'($urandom_range(0, N - 1)) : -1);
`endif
    end
    cyc();
    check("shift_queue_drained", exp_shift.size(), 0);
    check("rb_queue_drained", exp_out.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
